// File: rtl/dmem_responder_pkg.sv
// Shared encodings and access-decode helpers for the data-memory responder.
// Latency and backpressure are owned by dmem_responder; this file holds no state.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic        fp;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Zero-extending encodings exist only for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic wr);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return wr;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b10:   return off != 2'b00;
            2'b01:   return off[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_W:    return word;
            F3_BU:   return {24'h0, sh[7:0]};
            F3_HU:   return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Read data appears one cycle after the address; no backpressure, never stalls.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for integer and FP load/store paths sharing one array.
// Response WAIT_CYCLES+1 cycles after accept; mem_stall freezes the pipe until then.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enable,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_enable_f,
    input  logic        mem_write_f,
    input  logic [31:0] addr_f,
    input  logic [31:0] wdata_f,
    output logic [31:0] rdata,
    output logic [31:0] rdata_f,
    output logic        resp_valid,
    output logic        resp_valid_f,
    output logic        err,
    output logic        mem_stall
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             cur_q, cur_d;
    req_t             pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      rdata_f_q, rdata_f_d;

    req_t        int_req, fp_req, acc_req;
    logic        req_int, req_fp, accept, in_resp, cur_err;
    logic [3:0]  arr_we;
    logic [31:0] arr_rdata, resp_word;
    logic [AW-1:0] arr_raddr;

    assign req_int = mem_enable & (mem_read | mem_write);
    assign req_fp  = mem_enable_f;
    assign accept  = (state_q == ST_IDLE) & (pend_vld_q | req_int | req_fp);
    assign in_resp = (state_q == ST_RESP);

    always_comb begin
        int_req       = '0;
        int_req.fp    = 1'b0;
        int_req.wr    = mem_write;
        int_req.f3    = funct3;
        int_req.addr  = addr;
        int_req.wdata = wdata;

        fp_req        = '0;
        fp_req.fp     = 1'b1;
        fp_req.wr     = mem_write_f;
        fp_req.f3     = F3_W;
        fp_req.addr   = addr_f;
        fp_req.wdata  = wdata_f;

        // A parked FP request goes ahead of anything new in the same IDLE cycle.
        if (pend_vld_q) begin
            acc_req = pend_q;
        end else if (req_int) begin
            acc_req = int_req;
        end else begin
            acc_req = fp_req;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cur_d = acc_req;
                    if (pend_vld_q) begin
                        pend_vld_d = 1'b0;
                    end else if (req_int && req_fp) begin
                        pend_vld_d = 1'b1;
                        pend_d     = fp_req;
                    end
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cur_err = f3_illegal(cur_q.f3, cur_q.wr)
                   | misaligned(cur_q.f3, cur_q.addr[1:0])
                   | ({2'b00, cur_q.addr[31:2]} >= 32'(DEPTH_WORDS));

    // Array is read every cycle; the word latched on the edge into RESP is the answer.
    assign arr_raddr = (state_q == ST_IDLE) ? acc_req.addr[AW+1:2] : cur_q.addr[AW+1:2];
    assign arr_we    = (in_resp && cur_q.wr && !cur_err && !rst)
                     ? lane_mask(cur_q.f3, cur_q.addr[1:0]) : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .waddr_i (cur_q.addr[AW+1:2]),
        .wdata_i (store_lanes(cur_q.f3, cur_q.wdata)),
        .raddr_i (arr_raddr),
        .rdata_o (arr_rdata)
    );

    assign resp_word = (cur_err || cur_q.wr) ? 32'h0
                     : load_fmt(cur_q.f3, cur_q.addr[1:0], arr_rdata);

    assign rdata        = (in_resp && !cur_q.fp) ? resp_word : rdata_q;
    assign rdata_f      = (in_resp &&  cur_q.fp) ? resp_word : rdata_f_q;
    assign rdata_d      = rdata;
    assign rdata_f_d    = rdata_f;
    assign resp_valid   = in_resp & ~cur_q.fp & ~rst;
    assign resp_valid_f = in_resp &  cur_q.fp & ~rst;
    assign err          = in_resp & cur_err & ~rst;
    assign mem_stall    = ((state_q == ST_IDLE) & (pend_vld_q | req_int | req_fp))
                        | (state_q == ST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            rdata_q    <= '0;
            rdata_f_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            rdata_q    <= rdata_d;
            rdata_f_q  <= rdata_f_d;
        end
    end

endmodule
